// File: rtl/axi_fifo_burst_reader.sv
// Drains fixed-length bursts from the video FIFO read port onto an AXI4 write master.
// A 2-entry skid buffer hides the one-cycle FIFO read latency so W can stream at one beat per cycle.
module axi_fifo_burst_reader #(
    parameter int unsigned c_DATA_WIDTH   = 32,
    parameter int unsigned c_DEPTH_WIDTH  = 10,
    parameter int unsigned c_ADDR_WIDTH   = 28,
    parameter int unsigned c_BURST_LEN    = 16,
    parameter int unsigned c_BASE_ADDR    = 0,
    parameter int unsigned c_FRAME_BURSTS = 1200
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst_n,
    input  logic                      enable,
    output logic                      fifo_rd_en,
    input  logic [c_DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                      fifo_rd_empty,
    input  logic [c_DEPTH_WIDTH:0]    fifo_rd_water_level,
    output logic [c_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [c_DATA_WIDTH-1:0]   m_wdata,
    output logic [c_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      resp_err
);

    localparam int unsigned BYTES = c_DATA_WIDTH / 8;
    localparam int unsigned BCW   = (c_FRAME_BURSTS > 1) ? $clog2(c_FRAME_BURSTS) : 1;

    localparam logic [c_ADDR_WIDTH-1:0]  BASE       = c_ADDR_WIDTH'(c_BASE_ADDR);
    localparam logic [c_ADDR_WIDTH-1:0]  STRIDE     = c_ADDR_WIDTH'(c_BURST_LEN * BYTES);
    localparam logic [c_DEPTH_WIDTH:0]   LVL_NEED   = (c_DEPTH_WIDTH + 1)'(c_BURST_LEN);
    localparam logic [8:0]               RD_MAX     = 9'(c_BURST_LEN);
    localparam logic [7:0]               LAST_BEAT  = 8'(c_BURST_LEN - 1);
    localparam logic [BCW-1:0]           LAST_BURST = BCW'(c_FRAME_BURSTS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                    state_q;
    logic [c_DEPTH_WIDTH:0]    level_q;
    logic                      infl_q;
    logic [1:0]                occ_q, occ_d;
    logic [c_DATA_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
    logic [8:0]                rd_cnt_q;
    logic [7:0]                beat_q;
    logic [BCW-1:0]            burst_q;
    logic [c_ADDR_WIDTH-1:0]   awaddr_q;
    logic                      awvalid_q, bready_q, frame_done_q, resp_err_q;

    logic                      start, wfire, rd_en;
    logic [2:0]                occ_sum;

    assign m_awlen    = LAST_BEAT;
    assign m_awsize   = 3'($clog2(BYTES));
    assign m_awburst  = 2'b01;
    assign m_wstrb    = '1;
    assign m_awaddr   = awaddr_q;
    assign m_awvalid  = awvalid_q;
    assign m_bready   = bready_q;
    assign frame_done = frame_done_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != IDLE);
    assign m_wvalid   = (state_q == DATA) && (occ_q != 2'd0);
    assign m_wdata    = head_q;
    assign m_wlast    = m_wvalid && (beat_q == LAST_BEAT);
    assign fifo_rd_en = rd_en;

    // Level is registered before the compare, so a start trails the level by two cycles.
    assign start = enable && (level_q >= LVL_NEED);
    assign wfire = m_wvalid && m_wready;

    // Only issue a read if the word it returns is guaranteed a free skid slot on arrival.
    always_comb begin
        occ_sum = 3'(occ_q) + 3'(infl_q) - 3'(wfire);
        rd_en   = ((state_q == ADDR) || (state_q == DATA)) && (rd_cnt_q < RD_MAX) &&
                  !fifo_rd_empty && (occ_sum < 3'd2);
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({infl_q, wfire})
            2'b10: begin
                if (occ_q == 2'd0) head_d = fifo_rd_data;
                else               tail_d = fifo_rd_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = fifo_rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q      <= IDLE;
            level_q      <= '0;
            infl_q       <= 1'b0;
            occ_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            rd_cnt_q     <= '0;
            beat_q       <= '0;
            burst_q      <= '0;
            awaddr_q     <= BASE;
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            frame_done_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            level_q      <= fifo_rd_water_level;
            infl_q       <= rd_en;
            occ_q        <= occ_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            frame_done_q <= 1'b0;
            resp_err_q   <= 1'b0;
            if (rd_en) rd_cnt_q <= rd_cnt_q + 9'd1;

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= ADDR;
                        awvalid_q <= 1'b1;
                        rd_cnt_q  <= '0;
                    end
                end
                ADDR: begin
                    if (m_awready) begin
                        state_q   <= DATA;
                        awvalid_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (wfire) begin
                        if (m_wlast) begin
                            beat_q   <= '0;
                            state_q  <= RESP;
                            bready_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                RESP: begin
                    if (m_bvalid) begin
                        bready_q   <= 1'b0;
                        resp_err_q <= (m_bresp != 2'b00);
                        if (burst_q == LAST_BURST) begin
                            burst_q      <= '0;
                            awaddr_q     <= BASE;
                            frame_done_q <= 1'b1;
                        end else begin
                            burst_q  <= burst_q + BCW'(1);
                            awaddr_q <= awaddr_q + STRIDE;
                        end
                        if (start) begin
                            state_q   <= ADDR;
                            awvalid_q <= 1'b1;
                            rd_cnt_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_fifo_burst_reader.sv
// Bench for axi_fifo_burst_reader: behavioural FIFO, write-data scoreboard and burst address model.
module tb_axi_fifo_burst_reader;

    localparam int DW = 32;
    localparam int AW = 28;
    localparam int DEPW = 10;
    localparam int BL = 16;
    localparam int FRAME = 3;
    localparam logic [AW-1:0] BASE = 28'h100;
    localparam logic [AW-1:0] STRIDE = 28'h40;

    logic            clk, rst_n, enable;
    logic            fifo_rd_en, fifo_rd_empty;
    logic [DW-1:0]   fifo_rd_data;
    logic [DEPW:0]   level;
    logic [AW-1:0]   m_awaddr;
    logic [7:0]      m_awlen;
    logic [2:0]      m_awsize;
    logic [1:0]      m_awburst;
    logic            m_awvalid, m_awready;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_wlast, m_wvalid, m_wready;
    logic [1:0]      m_bresp;
    logic            m_bvalid, m_bready;
    logic            busy, frame_done, resp_err;

    axi_fifo_burst_reader #(
        .c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(DEPW), .c_ADDR_WIDTH(AW),
        .c_BURST_LEN(BL), .c_BASE_ADDR(32'h100), .c_FRAME_BURSTS(FRAME)
    ) dut (
        .rd_clk(clk), .rd_rst_n(rst_n), .enable(enable),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_water_level(level),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .frame_done(frame_done), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, valid the cycle after fifo_rd_en.
    logic [DW-1:0] mem [0:1023];
    logic [10:0]   wptr, rptr;
    logic          wr_en_tb;
    logic [DW-1:0] wr_data_tb;

    assign level = wptr - rptr;
    assign fifo_rd_empty = (level == 11'd0);

    always @(posedge clk) if (wr_en_tb) mem[wptr[9:0]] <= wr_data_tb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            fifo_rd_data <= '0;
        end else begin
            if (wr_en_tb) wptr <= wptr + 11'd1;
            if (fifo_rd_en) begin
                fifo_rd_data <= mem[rptr[9:0]];
                rptr <= rptr + 11'd1;
            end
        end
    end

    typedef struct {
        int         fill;
        bit         stall;
        logic [1:0] bresp;
        logic [AW-1:0] addr;
        bit         err;
        bit         fd;
    } vec_t;

    vec_t vecs [5];

    int            n_cmp, n_err;
    logic [DW-1:0] exp_q [$];
    int            wr_pend;
    logic [DW-1:0] wr_word;
    bit            stall_mode;
    logic [3:0]    wpat;
    int            wphase;
    int            aw_cnt, beat_cnt, rd_cnt_tb;
    int            last_aw, last_beats, last_rd;
    logic [AW-1:0] aw_addr_cap, last_awaddr;
    int            idx;
    bit            b_hs_pend, b_done, exp_fd_next, exp_err_next;
    logic          last_fd, last_err, last_post_awvalid;
    bit            prev_stall;
    logic [DW-1:0] prev_wdata;
    int            stray;
    logic          any_act;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        wr_pend = 0; wr_en_tb = 1'b0;
        aw_cnt = 0; beat_cnt = 0; rd_cnt_tb = 0;
        idx = 0; b_hs_pend = 0; prev_stall = 0;
    endtask

    // One clock: post-edge checks, drive inputs, then judge the handshakes of the coming edge.
    task automatic cycle();
        logic [DW-1:0] e;
        @(posedge clk); #1;
        if (b_hs_pend) begin
            chk("frame_done", frame_done, exp_fd_next);
            chk("resp_err", resp_err, exp_err_next);
            last_fd = frame_done; last_err = resp_err; last_post_awvalid = m_awvalid;
            b_hs_pend = 0; b_done = 1;
        end else if (frame_done || resp_err) begin
            stray++;
        end
        wr_en_tb = 1'b0;
        if (wr_pend > 0) begin
            wr_en_tb = 1'b1; wr_data_tb = wr_word;
            exp_q.push_back(wr_word);
            wr_word = wr_word + 32'h0101_0007;
            wr_pend--;
        end
        m_wready = stall_mode ? wpat[wphase] : 1'b1;
        wphase = (wphase + 1) % 4;
        #1;
        if (prev_stall) begin
            chk("stall_wvalid", m_wvalid, 1);
            chk("stall_wdata", m_wdata, prev_wdata);
        end
        prev_stall = m_wvalid && !m_wready;
        prev_wdata = m_wdata;
        if (m_awvalid && m_awready) begin
            chk("awaddr", m_awaddr, BASE + STRIDE * idx);
            aw_addr_cap = m_awaddr;
            aw_cnt++;
        end
        if (m_wvalid && m_wready) begin
            if (exp_q.size() == 0) begin
                chk("wbeat_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wdata", m_wdata, e);
            end
            chk("wlast", m_wlast, 64'(beat_cnt == BL - 1));
            beat_cnt++;
        end
        if (fifo_rd_en) begin
            chk("rd_while_empty", fifo_rd_empty, 0);
            rd_cnt_tb++;
            chk("reads_ahead_le2", 64'((rd_cnt_tb - beat_cnt) <= 2), 1);
        end
        if (m_bvalid && m_bready) begin
            exp_fd_next = (idx == FRAME - 1);
            exp_err_next = (m_bresp != 2'b00);
            idx = (idx + 1) % FRAME;
            last_aw = aw_cnt; last_beats = beat_cnt; last_rd = rd_cnt_tb; last_awaddr = aw_addr_cap;
            aw_cnt = 0; beat_cnt = 0; rd_cnt_tb = 0;
            b_hs_pend = 1;
        end
    endtask

    task automatic finish_burst();
        b_done = 0;
        for (int i = 0; i < 400 && !b_done; i++) cycle();
        chk("burst_done_in_budget", b_done, 1);
        chk("aw_handshakes", last_aw, 1);
        chk("w_beats", last_beats, BL);
        chk("rd_pulses", last_rd, BL);
    endtask

    initial begin
        vecs[0] = '{fill: 20, stall: 1'b0, bresp: 2'b10, addr: 28'h140, err: 1'b1, fd: 1'b0};
        vecs[1] = '{fill: 12, stall: 1'b1, bresp: 2'b00, addr: 28'h180, err: 1'b0, fd: 1'b1};
        vecs[2] = '{fill: 16, stall: 1'b1, bresp: 2'b00, addr: 28'h100, err: 1'b0, fd: 1'b0};
        vecs[3] = '{fill: 16, stall: 1'b0, bresp: 2'b11, addr: 28'h140, err: 1'b1, fd: 1'b0};
        vecs[4] = '{fill: 16, stall: 1'b1, bresp: 2'b00, addr: 28'h180, err: 1'b0, fd: 1'b1};

        n_cmp = 0; n_err = 0; stray = 0;
        wr_word = 32'hA000_0001; wpat = 4'b1001; wphase = 0; stall_mode = 0;
        enable = 1'b0; m_awready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00; m_wready = 1'b1;
        wr_data_tb = '0;
        clear_model();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) cycle();
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bready", m_bready, 0);
        chk("rst_awaddr", m_awaddr, BASE);
        chk("rst_wdata", m_wdata, 0);
        chk("awlen", m_awlen, BL - 1);
        chk("awsize", m_awsize, 2);
        chk("awburst", m_awburst, 1);
        chk("wstrb", m_wstrb, 4'hF);
        rst_n = 1'b1;
        enable = 1'b1;

        // Level 15 must not start; the 16th word starts AW two cycles after it lands.
        wr_pend = 15;
        any_act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            any_act = any_act | m_awvalid | busy;
        end
        chk("no_start_at_level15", any_act, 0);
        wr_pend = 1;
        cycle();
        cycle();
        chk("awvalid_level16_c0", m_awvalid, 0);
        cycle();
        chk("awvalid_level16_c1", m_awvalid, 0);
        cycle();
        chk("awvalid_level16_c2", m_awvalid, 1);
        finish_burst();
        chk("burst0_addr", last_awaddr, BASE);

        for (int v = 0; v < 5; v++) begin
            stall_mode = vecs[v].stall;
            m_bresp = vecs[v].bresp;
            wr_pend = vecs[v].fill;
            finish_burst();
            chk("tbl_addr", last_awaddr, vecs[v].addr);
            chk("tbl_resp_err", last_err, vecs[v].err);
            chk("tbl_frame_done", last_fd, vecs[v].fd);
        end

        // Back-to-back: B handshake with start already true goes straight to ADDR.
        stall_mode = 0; m_bresp = 2'b00;
        wr_pend = 32;
        finish_burst();
        chk("b2b_first_addr", last_awaddr, 28'h100);
        chk("b2b_direct_addr", last_post_awvalid, 1);
        enable = 1'b0;
        wr_pend = 16;
        finish_burst();
        chk("b2b_second_addr", last_awaddr, 28'h140);
        any_act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            any_act = any_act | m_awvalid | busy;
        end
        chk("idle_when_disabled", any_act, 0);

        // Reset in the middle of a burst abandons it; the next burst restarts at base.
        enable = 1'b1;
        stall_mode = 1;
        for (int i = 0; i < 200 && beat_cnt < 7; i++) cycle();
        chk("reached_beat7", beat_cnt, 7);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rd_en", fifo_rd_en, 0);
        chk("arst_awvalid", m_awvalid, 0);
        chk("arst_wvalid", m_wvalid, 0);
        chk("arst_wlast", m_wlast, 0);
        chk("arst_bready", m_bready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pulses", {frame_done, resp_err}, 0);
        chk("arst_awaddr", m_awaddr, BASE);
        clear_model();
        repeat (2) cycle();
        rst_n = 1'b1;
        stall_mode = 0;
        wr_pend = 16;
        finish_burst();
        chk("post_reset_addr", last_awaddr, BASE);

        chk("stray_pulses", stray, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_fifo_burst_reader.md
Name: axi_fifo_burst_reader

Overview:
- Read-side consumer of the video AXI FIFO: watches the FIFO read water level and drains fixed-length bursts onto an AXI4 write master (AW/W/B) toward the DDR controller.
- Sits between the FIFO read port (rd_en, rd_data, rd_empty, rd_water_level) and the DDR AXI slave port.
- Walks a frame buffer of FRAME_BURSTS bursts starting at BASE_ADDR, then wraps.

Parameters:
- c_DATA_WIDTH, 32: FIFO read data width = AXI wdata width; power of 2, 32..256.
- c_DEPTH_WIDTH, 10: FIFO read depth width; water-level input is c_DEPTH_WIDTH+1 bits.
- c_ADDR_WIDTH, 28: AXI address width.
- c_BURST_LEN, 16: beats per burst, 1..256; must be ≤ 2^c_DEPTH_WIDTH.
- c_BASE_ADDR, 0: byte address of the first burst of each frame.
- c_FRAME_BURSTS, 1200: bursts per frame before the address wraps.

Ports:
- rd_clk, in, 1: single clock, shared with the FIFO read port.
- rd_rst_n, in, 1: asynchronous active-low reset.
- enable, in, 1: level; permits starting new bursts.
- fifo_rd_en, out, 1: FIFO read enable.
- fifo_rd_data, in, c_DATA_WIDTH: FIFO data; valid the cycle after fifo_rd_en (no output register).
- fifo_rd_empty, in, 1: FIFO empty.
- fifo_rd_water_level, in, c_DEPTH_WIDTH+1: FIFO occupancy.
- m_awaddr, out, c_ADDR_WIDTH: burst byte address.
- m_awlen, out, 8: constant c_BURST_LEN-1.
- m_awsize, out, 3: constant log2(c_DATA_WIDTH/8).
- m_awburst, out, 2: constant 2'b01 (INCR).
- m_awvalid, out, 1 / m_awready, in, 1: AW handshake.
- m_wdata, out, c_DATA_WIDTH: write data.
- m_wstrb, out, c_DATA_WIDTH/8: all ones.
- m_wlast, out, 1: last beat of the burst.
- m_wvalid, out, 1 / m_wready, in, 1: W handshake.
- m_bresp, in, 2 / m_bvalid, in, 1 / m_bready, out, 1: B channel.
- busy, out, 1: state is not IDLE.
- frame_done, out, 1: one-cycle pulse when the B response of the last burst in a frame is accepted.
- resp_err, out, 1: one-cycle pulse on an accepted B response with m_bresp != 2'b00.

Behaviour:

Reset and constants:
- rd_rst_n low forces, asynchronously, state=IDLE and deasserts fifo_rd_en, m_awvalid, m_wvalid, m_wlast, m_bready, busy, frame_done and resp_err.
- Reset also sets m_awaddr=c_BASE_ADDR, clears the burst counter, beat counter, read counter and skid occupancy, and sets m_wdata=0.
- Reset mid-burst abandons the burst. The system resets the FIFO and the AXI slave alongside this block.

State machine (IDLE, ADDR, DATA, RESP):
- IDLE → ADDR when enable=1 and fifo_rd_water_level ≥ c_BURST_LEN. m_awvalid rises on the cycle of entry to ADDR.
- ADDR: m_awvalid holds with m_awaddr stable until m_awready. On that handshake → DATA.
- DATA: beats stream out. The W handshake with m_wlast=1 (beat c_BURST_LEN) → RESP.
- RESP: m_bready=1. On m_bvalid → IDLE, or directly → ADDR if the start condition already holds that cycle.
- Deasserting enable never aborts a burst; the current burst completes through RESP, then the block stays in IDLE.

FIFO read pipeline:
- Reads may be issued in ADDR and DATA so that read latency is hidden.
- The block holds a 2-entry skid buffer. occ = entries held; infl = 1 if fifo_rd_en was high in the previous cycle.
- fifo_rd_en = (ADDR or DATA) and rd_cnt < c_BURST_LEN and !fifo_rd_empty and (occ + infl − wfire) < 2, where wfire = m_wvalid & m_wready.
- rd_cnt counts reads issued in the current burst and clears on entry to ADDR.
- fifo_rd_en never asserts while fifo_rd_empty=1.
- m_wvalid = DATA and occ > 0. m_wdata is the buffer head.
- m_wdata/m_wvalid stay stable while m_wvalid & !m_wready (AXI rule).
- Throughput: 1 beat per cycle with m_wready held at 1.

Counters and address:
- Beat counter runs 0..c_BURST_LEN−1. m_wlast = m_wvalid and count == c_BURST_LEN−1.
- After each B handshake, m_awaddr += c_BURST_LEN*c_DATA_WIDTH/8, modulo 2^c_ADDR_WIDTH.
- The burst counter increments on each B handshake. At c_FRAME_BURSTS−1 it resets to 0, m_awaddr reloads c_BASE_ADDR, and frame_done pulses.
- resp_err does not halt operation; the address advances anyway.

Simultaneous events:
- Push into and pop from the skid buffer in the same cycle leaves occ unchanged.
- A B handshake and a new start condition in the same cycle go straight to ADDR with the updated address.

Test Plan:
1. Reset with FIFO level 20, enable=1, m_awready=m_wready=m_bvalid=1, c_BURST_LEN=16 → m_awaddr=0x0, m_awlen=15; 16 consecutive W beats carry FIFO words in order, m_wlast only on beat 16; exactly 16 fifo_rd_en pulses.
2. Level 15, then a write raises it to 16 → no m_awvalid while level is 15; m_awvalid rises 2 cycles after the level reaches 16 (one cycle to register level, one to enter ADDR).
3. m_wready toggles 1,0,0,1 repeatedly during DATA → no beat lost or duplicated, m_wdata stable while stalled, occ never exceeds 2, never a read while empty.
4. c_FRAME_BURSTS=3, c_BASE_ADDR=0x100, 32-bit data → addresses 0x100, 0x140, 0x180, 0x100; frame_done pulses once, on the third B handshake.
5. m_bresp=2'b10 on burst 2 → resp_err pulses once; burst 3 address is still 0x180.
6. rd_rst_n low at beat 7 → all outputs deassert asynchronously; after release with enable=1 and level ≥16, the next burst starts at c_BASE_ADDR.
